// File: rtl/pc_sequencer_pkg.sv
// Shared types and branch target table for the program-counter sequencer.
// Table values are 16-bit two's complement so relative offsets can be negative.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } pc_state_t;

   localparam int LUT_W = 16;

   // Branch target table, kept in step with the assembler's symbol export.
   localparam logic [LUT_W-1:0] LUT_ENTRY_0 = 16'd10;
   localparam logic [LUT_W-1:0] LUT_ENTRY_1 = 16'd100;
   localparam logic [LUT_W-1:0] LUT_ENTRY_2 = 16'hFFFE;
   localparam logic [LUT_W-1:0] LUT_ENTRY_3 = 16'd40;
   localparam logic [LUT_W-1:0] LUT_ENTRY_4 = 16'hFFFC;
   localparam logic [LUT_W-1:0] LUT_ENTRY_5 = 16'd500;
   localparam logic [LUT_W-1:0] LUT_ENTRY_6 = 16'd1020;
   localparam logic [LUT_W-1:0] LUT_ENTRY_7 = 16'd5;

endpackage

// File: rtl/pc_sequencer_branch_lut.sv
// Combinational branch target lookup: instruction index -> PC-width target.
module branch_lut
   import pc_sequencer_pkg::*;
#(
   parameter int PC_W      = 10,
   parameter int LUT_IDX_W = 5
) (
   input  logic [LUT_IDX_W-1:0] index,
   output logic [PC_W-1:0]      target
);

   logic [LUT_W-1:0] raw;

   always_comb begin
      raw = '0;
      case (index)
         LUT_IDX_W'(0): raw = LUT_ENTRY_0;
         LUT_IDX_W'(1): raw = LUT_ENTRY_1;
         LUT_IDX_W'(2): raw = LUT_ENTRY_2;
         LUT_IDX_W'(3): raw = LUT_ENTRY_3;
         LUT_IDX_W'(4): raw = LUT_ENTRY_4;
         LUT_IDX_W'(5): raw = LUT_ENTRY_5;
         LUT_IDX_W'(6): raw = LUT_ENTRY_6;
         LUT_IDX_W'(7): raw = LUT_ENTRY_7;
         default:       raw = '0;
      endcase
   end

   // Sign-extend so negative offsets stay negative if PC_W ever exceeds the table width.
   assign target = PC_W'($signed(raw));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch address generation, branch/halt handling,
// Start/Done program handshake and a saturating RUN cycle counter.
//
//   state | meaning
//   IDLE  | out of reset, waiting for Start
//   RUN   | fetching; PC advances unless stalled
//   DONE  | halted at halt instruction, Done high, waiting for Start
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int PC_W       = 10,
   parameter int LUT_IDX_W  = 5,
   parameter int START_ADDR = 0,
   parameter int CNT_W      = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic                 Stall,
   input  logic                 Halt,
   input  logic                 BranchEn,
   input  logic                 BranchRel,
   input  logic [LUT_IDX_W-1:0] TargetSel,
   input  logic                 Cond,
   output logic [PC_W-1:0]      ProgCtr,
   output logic                 Busy,
   output logic                 Done,
   output logic [CNT_W-1:0]     CycleCount
);

   localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

   pc_state_t       state;
   logic [PC_W-1:0] lut_target;
   logic [PC_W-1:0] pc_next;
   logic            branch_taken;

   branch_lut #(
      .PC_W      (PC_W),
      .LUT_IDX_W (LUT_IDX_W)
   ) u_branch_lut (
      .index  (TargetSel),
      .target (lut_target)
   );

   // BranchEn gates Cond so an undriven compare result cannot reach the PC.
   assign branch_taken = BranchEn & Cond;

   always_comb begin
      pc_next = ProgCtr + 1'b1;
      if (branch_taken) begin
         pc_next = BranchRel ? (ProgCtr + lut_target) : lut_target;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         ProgCtr    <= START_PC;
         Busy       <= 1'b0;
         Done       <= 1'b0;
         CycleCount <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (Start) begin
                  state      <= RUN;
                  ProgCtr    <= START_PC;
                  Busy       <= 1'b1;
                  Done       <= 1'b0;
                  CycleCount <= '0;
               end
            end
            RUN: begin
               if (!Stall) begin
                  if (CycleCount != '1) begin
                     CycleCount <= CycleCount + 1'b1;
                  end
                  if (Halt) begin
                     state <= DONE;
                     Busy  <= 1'b0;
                     Done  <= 1'b1;
                  end else begin
                     ProgCtr <= pc_next;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               ProgCtr <= START_PC;
               Busy    <= 1'b0;
               Done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
